fft_out_reorder: RTL and testbench

- Consumes the 1024-point FFT core's output stream: 32-bit samples with `sync_o` marking sample 0 of each frame, in bit-reversed order.
- Writes each frame into one half of a ping-pong buffer at bit-reversed addresses, then streams it out in natural bin order over a valid/ready interface.
- Sits directly downstream of the FFT core and feeds the SoftCast per-bin processing.

---
 rtl/fft_out_reorder_if.sv | 28 ++
 rtl/fft_out_reorder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_fft_out_reorder.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fft_out_reorder_if.sv
// Stream bundle around the FFT output reorder buffer: bit-reversed input
// samples in, natural-order bins out over valid/ready.
interface fft_out_reorder_if #(
  parameter int DATA_W = 32,
  parameter int LOG2N  = 10
) ();
  logic              in_valid;
  logic              sync_i;
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              out_ready;
  logic              out_sof;
  logic              out_eof;
  logic [LOG2N-1:0]  out_index;
  logic              frame_err;
  logic              overflow;

  modport master (
    output in_valid, sync_i, data_in, out_ready,
    input  data_out, out_valid, out_sof, out_eof, out_index, frame_err, overflow
  );

  modport slave (
    input  in_valid, sync_i, data_in, out_ready,
    output data_out, out_valid, out_sof, out_eof, out_index, frame_err, overflow
  );
endinterface

// File: rtl/fft_out_reorder.sv
// Ping-pong reorder buffer: frames are written at bit-reversed addresses and
// streamed out in natural bin order with a one-entry skid behind the RAM read.
module fft_out_reorder #(
  parameter int DATA_W      = 32,
  parameter int LOG2N       = 10,
  parameter bit BIT_REVERSE = 1'b1
) (
  input logic              clk,
  input logic              rst,
  fft_out_reorder_if.slave bus
);
  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] CNT_ZERO = LOG2N'(0);
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);
  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(N - 1);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_FILL = 2'd1,
    W_DROP = 2'd2
  } wstate_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_RUN  = 1'b1
  } rstate_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    r = CNT_ZERO;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  logic [DATA_W-1:0] mem0 [N];
  logic [DATA_W-1:0] mem1 [N];
  logic [DATA_W-1:0] rdata0_r;
  logic [DATA_W-1:0] rdata1_r;

  wstate_t          wstate_r, wstate_s;
  logic [LOG2N-1:0] wcnt_r, wcnt_s;
  logic [LOG2N-1:0] wptr_s;
  logic [LOG2N-1:0] waddr_s;
  logic             wbank_r, wbank_s;
  logic             we_s;
  logic             start_s;
  logic             set_full_s;
  logic             frame_err_s, frame_err_r;
  logic             overflow_s, overflow_r;
  logic [1:0]       full_r;
  logic [1:0]       set_mask_s;
  logic [1:0]       clr_mask_s;

  rstate_t          rstate_r, rstate_s;
  logic [LOG2N-1:0] rcnt_r, rcnt_s;
  logic             ibank_r, ibank_s;
  logic             rbank_r;
  logic             busy_r, busy_s;
  logic             issue_s;
  logic             pend_r;
  logic             pend_bank_r;
  logic [LOG2N-1:0] pend_idx_r;
  logic [DATA_W-1:0] pend_data_s;
  logic             accept_s;
  logic             load_s;
  logic             retire_s;
  logic             room_s;

  logic [DATA_W-1:0] data_out_r;
  logic [LOG2N-1:0]  out_index_r;
  logic              out_valid_r;
  logic              out_sof_r;
  logic              out_eof_r;

  assign start_s = bus.in_valid && bus.sync_i;

  // Write-side next state: capture, abort on early sync, drop when the bank is busy.
  always_comb begin
    wstate_s    = wstate_r;
    wcnt_s      = wcnt_r;
    wbank_s     = wbank_r;
    wptr_s      = wcnt_r;
    we_s        = 1'b0;
    set_full_s  = 1'b0;
    frame_err_s = 1'b0;
    overflow_s  = 1'b0;
    case (wstate_r)
      W_IDLE, W_DROP: begin
        if (start_s && full_r[wbank_r]) begin
          overflow_s = 1'b1;
          wcnt_s     = CNT_ONE;
          wstate_s   = W_DROP;
        end else if (start_s) begin
          we_s     = 1'b1;
          wptr_s   = CNT_ZERO;
          wcnt_s   = CNT_ONE;
          wstate_s = W_FILL;
        end else if (bus.in_valid && (wstate_r == W_DROP)) begin
          wcnt_s   = wcnt_r + CNT_ONE;
          wstate_s = (wcnt_r == CNT_LAST) ? W_IDLE : W_DROP;
        end else begin
          wstate_s = wstate_r;
        end
      end
      W_FILL: begin
        if (start_s) begin
          frame_err_s = 1'b1;
          we_s        = 1'b1;
          wptr_s      = CNT_ZERO;
          wcnt_s      = CNT_ONE;
        end else if (bus.in_valid) begin
          we_s   = 1'b1;
          wcnt_s = wcnt_r + CNT_ONE;
          if (wcnt_r == CNT_LAST) begin
            set_full_s = 1'b1;
            wbank_s    = ~wbank_r;
            wstate_s   = W_IDLE;
          end else begin
            wstate_s = W_FILL;
          end
        end else begin
          wstate_s = W_FILL;
        end
      end
      default: begin
        wstate_s = W_IDLE;
        wcnt_s   = CNT_ZERO;
      end
    endcase
  end

  assign waddr_s    = BIT_REVERSE ? bitrev(wptr_s) : wptr_s;
  assign set_mask_s = set_full_s ? (wbank_r ? 2'b10 : 2'b01) : 2'b00;
  assign clr_mask_s = retire_s ? (rbank_r ? 2'b10 : 2'b01) : 2'b00;

  // Write-side state, bank-full flags and the status pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wstate_r    <= W_IDLE;
      wcnt_r      <= CNT_ZERO;
      wbank_r     <= 1'b0;
      rbank_r     <= 1'b0;
      full_r      <= 2'b00;
      frame_err_r <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      wstate_r    <= wstate_s;
      wcnt_r      <= wcnt_s;
      wbank_r     <= wbank_s;
      rbank_r     <= rbank_r ^ retire_s;
      full_r      <= (full_r | set_mask_s) & ~clr_mask_s;
      frame_err_r <= frame_err_s;
      overflow_r  <= overflow_s;
    end
  end

  // Bank 0 storage: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (we_s && !wbank_r) begin
      mem0[waddr_s] <= bus.data_in;
    end
    if (issue_s && !ibank_r) begin
      rdata0_r <= mem0[rcnt_r];
    end
  end

  // Bank 1 storage: one write port, one registered read port.
  always_ff @(posedge clk) begin
    if (we_s && wbank_r) begin
      mem1[waddr_s] <= bus.data_in;
    end
    if (issue_s && ibank_r) begin
      rdata1_r <= mem1[rcnt_r];
    end
  end

  // The issue bank runs ahead of the retire bank so a full next bank streams with no bubble.
  assign accept_s    = out_valid_r && bus.out_ready;
  assign load_s      = pend_r && (!out_valid_r || bus.out_ready);
  assign retire_s    = accept_s && out_eof_r;
  assign room_s      = !pend_r || load_s;
  assign pend_data_s = pend_bank_r ? rdata1_r : rdata0_r;

  // Read-side next state: address issue and return to idle after the last bin.
  always_comb begin
    rstate_s = rstate_r;
    rcnt_s   = rcnt_r;
    ibank_s  = ibank_r;
    busy_s   = busy_r;
    issue_s  = 1'b0;
    case (rstate_r)
      R_IDLE: begin
        if (full_r[ibank_r]) begin
          issue_s  = 1'b1;
          rcnt_s   = rcnt_r + CNT_ONE;
          busy_s   = 1'b1;
          rstate_s = R_RUN;
        end else begin
          rstate_s = R_IDLE;
        end
      end
      R_RUN: begin
        if (busy_r && room_s) begin
          issue_s = 1'b1;
          rcnt_s  = rcnt_r + CNT_ONE;
          if (rcnt_r == CNT_LAST) begin
            busy_s  = 1'b0;
            ibank_s = ~ibank_r;
          end else begin
            busy_s = 1'b1;
          end
        end else if (!busy_r && room_s && full_r[ibank_r]) begin
          issue_s = 1'b1;
          rcnt_s  = rcnt_r + CNT_ONE;
          busy_s  = 1'b1;
        end else begin
          busy_s = busy_r;
        end
        if (retire_s && !busy_r && !pend_r && !issue_s) begin
          rstate_s = R_IDLE;
        end else begin
          rstate_s = R_RUN;
        end
      end
      default: begin
        rstate_s = R_IDLE;
        busy_s   = 1'b0;
      end
    endcase
  end

  // Read-side state, RAM-output tracking and the held output register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rstate_r    <= R_IDLE;
      rcnt_r      <= CNT_ZERO;
      ibank_r     <= 1'b0;
      busy_r      <= 1'b0;
      pend_r      <= 1'b0;
      pend_bank_r <= 1'b0;
      pend_idx_r  <= CNT_ZERO;
      out_valid_r <= 1'b0;
      data_out_r  <= {DATA_W{1'b0}};
      out_index_r <= CNT_ZERO;
      out_sof_r   <= 1'b0;
      out_eof_r   <= 1'b0;
    end else begin
      rstate_r <= rstate_s;
      rcnt_r   <= rcnt_s;
      ibank_r  <= ibank_s;
      busy_r   <= busy_s;
      if (issue_s) begin
        pend_r      <= 1'b1;
        pend_bank_r <= ibank_r;
        pend_idx_r  <= rcnt_r;
      end else if (load_s) begin
        pend_r <= 1'b0;
      end else begin
        pend_r <= pend_r;
      end
      if (load_s) begin
        out_valid_r <= 1'b1;
        data_out_r  <= pend_data_s;
        out_index_r <= pend_idx_r;
        out_sof_r   <= (pend_idx_r == CNT_ZERO);
        out_eof_r   <= (pend_idx_r == CNT_LAST);
      end else if (accept_s) begin
        out_valid_r <= 1'b0;
      end else begin
        out_valid_r <= out_valid_r;
      end
    end
  end

  assign bus.data_out  = data_out_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_index = out_index_r;
  assign bus.out_sof   = out_sof_r;
  assign bus.out_eof   = out_eof_r;
  assign bus.frame_err = frame_err_r;
  assign bus.overflow  = overflow_r;
endmodule

// File: tb/tb_fft_out_reorder.sv
// Directed scenarios with random data; expected bins come from a frame-level
// model that places write sample k at natural bin bitrev(k).
module tb_fft_out_reorder;
  localparam int DATA_W = 32;
  localparam int LOG2N  = 10;
  localparam int N      = 1024;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fft_out_reorder_if #(.DATA_W(DATA_W), .LOG2N(LOG2N)) bus ();

  fft_out_reorder #(.DATA_W(DATA_W), .LOG2N(LOG2N), .BIT_REVERSE(1'b1)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ovf_cnt, ferr_cnt, first_valid_cyc, last_in_cyc, ready_mode;
  logic [31:0] rx_data[$];
  int          rx_idx[$];
  bit          rx_sof[$];
  bit          rx_eof[$];
  int          rx_cyc[$];
  logic [31:0] exp_q[$];
  logic [31:0] sent[$];
  bit          stall_prev;
  logic [31:0] held_data;
  logic [9:0]  held_idx;
  logic        held_sof, held_eof;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      $error("check %s", tag);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Output observer: handshakes, status pulses and stall stability.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (bus.overflow) ovf_cnt++;
      if (bus.frame_err) ferr_cnt++;
      if (bus.out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stall_prev)
        check("stall_hold", {bus.out_valid, bus.data_out, bus.out_index, bus.out_sof, bus.out_eof},
              {1'b1, held_data, held_idx, held_sof, held_eof});
      if (bus.out_valid && bus.out_ready) begin
        rx_data.push_back(bus.data_out);
        rx_idx.push_back(int'(bus.out_index));
        rx_sof.push_back(bus.out_sof);
        rx_eof.push_back(bus.out_eof);
        rx_cyc.push_back(cyc);
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_data  = bus.data_out;
      held_idx   = bus.out_index;
      held_sof   = bus.out_sof;
      held_eof   = bus.out_eof;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #2;
      if (ready_mode != 0) bus.out_ready = 1'($urandom_range(1, 0));
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int rev(input int k);
    int r = 0;
    for (int b = 0; b < LOG2N; b++) begin
      r = r * 2 + (k % 2);
      k = k / 2;
    end
    return r;
  endfunction

  task automatic send(input int count, input bit idx_data, input int gap_pct, input bit with_sync);
    logic [31:0] d;
    sent.delete();
    for (int k = 0; k < count; k++) begin
      while (gap_pct != 0 && $urandom_range(99, 0) < gap_pct) begin
        bus.in_valid = 1'b0;
        bus.sync_i   = 1'b0;
        tick(1);
      end
      d = idx_data ? 32'(k) : $urandom;
      bus.in_valid = 1'b1;
      bus.sync_i   = with_sync && (k == 0);
      bus.data_in  = d;
      sent.push_back(d);
      last_in_cyc = cyc;
      tick(1);
    end
    bus.in_valid = 1'b0;
    bus.sync_i   = 1'b0;
  endtask

  task automatic expect_frame();
    logic [31:0] nat [N];
    for (int k = 0; k < N; k++) nat[rev(k)] = sent[k];
    for (int j = 0; j < N; j++) exp_q.push_back(nat[j]);
  endtask

  task automatic clear_obs();
    rx_data.delete(); rx_idx.delete(); rx_sof.delete(); rx_eof.delete(); rx_cyc.delete();
    exp_q.delete();
    ovf_cnt = 0;
    ferr_cnt = 0;
    first_valid_cyc = -1;
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int t = 0;
    while (rx_data.size() < n && t < budget) begin
      tick(1);
      t++;
    end
    check({tag, "_rx_timeout"}, rx_data.size() >= n, 1);
  endtask

  task automatic compare_stream(input string tag);
    check({tag, "_count"}, rx_data.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < rx_data.size(); i++) begin
      check({tag, "_data"}, rx_data[i], exp_q[i]);
      check({tag, "_index"}, rx_idx[i], i % N);
      check({tag, "_sof"}, rx_sof[i], (i % N) == 0);
      check({tag, "_eof"}, rx_eof[i], (i % N) == N - 1);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.sync_i = 1'b0; bus.data_in = '0; bus.out_ready = 1'b0;
    ready_mode = 0;
    clear_obs();
    rst = 1'b1;
    tick(3);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_data_out", bus.data_out, 0);
    check("reset_out_index", bus.out_index, 0);
    check("reset_sof_eof", {bus.out_sof, bus.out_eof}, 0);
    check("reset_pulses", {bus.frame_err, bus.overflow}, 0);
    rst = 1'b0;
    tick(2);

    // Single frame, data = write index
    clear_obs();
    bus.out_ready = 1'b1;
    send(N, 1'b1, 0, 1'b1);
    expect_frame();
    wait_rx("single", N, 3000);
    tick(20);
    compare_stream("single");
    check("single_latency", first_valid_cyc, last_in_cyc + 3);
    if (rx_data.size() >= N) begin
      check("single_bin1", rx_data[1], 512);
      check("single_bin2", rx_data[2], 256);
      check("single_bin1023", rx_data[N-1], 1023);
    end

    // Backpressure with random input gaps
    clear_obs();
    ready_mode = 1;
    send(N, 1'b0, 20, 1'b1);
    expect_frame();
    wait_rx("bp", N, 20000);
    ready_mode = 0;
    bus.out_ready = 1'b1;
    tick(20);
    compare_stream("bp");
    check("bp_pulses", ovf_cnt + ferr_cnt, 0);

    // Back-to-back frames: 1 and 2 contiguous, 3 after the first bank frees
    clear_obs();
    send(N, 1'b0, 0, 1'b1);
    expect_frame();
    send(N, 1'b0, 0, 1'b1);
    expect_frame();
    tick(16);
    send(N, 1'b0, 0, 1'b1);
    expect_frame();
    wait_rx("b2b", 3 * N, 6000);
    tick(20);
    compare_stream("b2b");
    check("b2b_overflow", ovf_cnt, 0);
    if (rx_cyc.size() > N) check("b2b_no_gap", rx_cyc[N] - rx_cyc[N-1], 1);

    // Overflow: A and B fill both banks while stalled, C is dropped
    clear_obs();
    bus.out_ready = 1'b0;
    send(N, 1'b0, 0, 1'b1);
    expect_frame();
    send(N, 1'b0, 0, 1'b1);
    expect_frame();
    tick(4);
    send(N, 1'b0, 0, 1'b1);
    tick(5);
    check("ovf_pulse_count", ovf_cnt, 1);
    check("ovf_no_output_stalled", rx_data.size(), 0);
    bus.out_ready = 1'b1;
    wait_rx("ovf", 2 * N, 5000);
    tick(20);
    compare_stream("ovf");
    check("ovf_frame_err", ferr_cnt, 0);

    // Early sync at write index 500
    clear_obs();
    send(500, 1'b0, 0, 1'b1);
    send(N, 1'b0, 10, 1'b1);
    expect_frame();
    wait_rx("early", N, 5000);
    tick(20);
    compare_stream("early");
    check("early_frame_err", ferr_cnt, 1);
    check("early_overflow", ovf_cnt, 0);

    // Reset during output bin 300
    clear_obs();
    send(N, 1'b0, 0, 1'b1);
    wait_rx("rstmid", 300, 3000);
    rst = 1'b1;
    #1;
    check("rstmid_outputs_zero",
          {bus.out_valid, bus.data_out, bus.out_index, bus.out_sof, bus.out_eof, bus.frame_err, bus.overflow}, 0);
    tick(3);
    rst = 1'b0;
    clear_obs();
    send(N, 1'b0, 0, 1'b0);
    tick(40);
    check("rstmid_no_output", rx_data.size(), 0);
    check("rstmid_no_valid", first_valid_cyc, -1);
    check("rstmid_no_pulses", ovf_cnt + ferr_cnt, 0);
    send(N, 1'b0, 0, 1'b1);
    expect_frame();
    wait_rx("rstmid", N, 3000);
    tick(20);
    compare_stream("rstmid");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
